// File: rtl/sobel_grad_mem_ctrl_if.sv
// Bundle of producer, pair-consumer and memory-port signals of the Sobel gradient memory controller.
// The controller uses the slave side; the surrounding datapath uses the master side.
interface sobel_grad_mem_ctrl_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 12
);
    logic          gx_valid;
    logic [DW-1:0] gx_data;
    logic          gx_ready;
    logic          gy_valid;
    logic [DW-1:0] gy_data;
    logic          gy_ready;
    logic          pair_valid;
    logic [DW-1:0] pair_gx;
    logic [DW-1:0] pair_gy;
    logic          pair_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_data_out;
    logic [AW-1:0] gx_count;
    logic [AW-1:0] gy_count;

    modport master (
        output gx_valid, gx_data, gy_valid, gy_data, pair_ready, mem_data_out,
        input  gx_ready, gy_ready, pair_valid, pair_gx, pair_gy,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        input  gx_count, gy_count
    );

    modport slave (
        input  gx_valid, gx_data, gy_valid, gy_data, pair_ready, mem_data_out,
        output gx_ready, gy_ready, pair_valid, pair_gx, pair_gy,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        output gx_count, gy_count
    );
endinterface

// File: rtl/sobel_grad_mem_ctrl.sv
// Sobel gradient memory controller: round-robin Gx/Gy writes into two circular halves
// of a single memory, and a read sequencer that delivers matched Gx/Gy pairs.
module sobel_grad_mem_ctrl #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 12
) (
    input logic               clk,
    input logic               rst,
    sobel_grad_mem_ctrl_if.slave bus
);
    localparam int unsigned PW    = AW - 1;
    localparam int unsigned DEPTH = 1 << PW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_Y = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] gx_wptr;
    logic [PW-1:0] gy_wptr;
    logic [PW-1:0] gx_rptr;
    logic [PW-1:0] gy_rptr;
    logic [AW-1:0] gx_count;
    logic [AW-1:0] gy_count;
    logic          prio;
    logic          pair_valid;
    logic [DW-1:0] pair_gx;
    logic [DW-1:0] pair_gy;

    logic          elig_x;
    logic          elig_y;
    logic          grant_x;
    logic          grant_y;
    logic          pop;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          ld_gx;
    logic          ld_gy;

    // Round-robin write arbitration; everything is held off while in reset.
    always_comb begin
        elig_x  = bus.gx_valid & (gx_count != AW'(DEPTH)) & ~rst;
        elig_y  = bus.gy_valid & (gy_count != AW'(DEPTH)) & ~rst;
        grant_x = elig_x & (~elig_y | ~prio);
        grant_y = elig_y & (~elig_x | prio);
    end

    always_comb begin
        bus.mem_wr_en   = grant_x | grant_y;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        if (grant_x) begin
            bus.mem_wr_addr = {1'b0, gx_wptr};
            bus.mem_wr_data = bus.gx_data;
        end else if (grant_y) begin
            bus.mem_wr_addr = {1'b1, gy_wptr};
            bus.mem_wr_data = bus.gy_data;
        end
    end

    assign pop = pair_valid & bus.pair_ready;

    // Read sequencer: Gx read, Gy read, capture, then hold the pair until accepted.
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        rd_addr  = '0;
        ld_gx    = 1'b0;
        ld_gy    = 1'b0;
        unique case (state)
            IDLE: begin
                if (gx_count != '0 && gy_count != '0) begin
                    rd_en    = 1'b1;
                    rd_addr  = {1'b0, gx_rptr};
                    state_nx = RD_Y;
                end
            end
            RD_Y: begin
                rd_en    = 1'b1;
                rd_addr  = {1'b1, gy_rptr};
                ld_gx    = 1'b1;
                state_nx = CAP;
            end
            CAP: begin
                ld_gy    = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                if (pop) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_wptr    <= '0;
            gy_wptr    <= '0;
            gx_rptr    <= '0;
            gy_rptr    <= '0;
            gx_count   <= '0;
            gy_count   <= '0;
            prio       <= 1'b0;
            pair_valid <= 1'b0;
            pair_gx    <= '0;
            pair_gy    <= '0;
        end else begin
            if (grant_x) gx_wptr <= gx_wptr + PW'(1);
            if (grant_y) gy_wptr <= gy_wptr + PW'(1);
            if (pop) begin
                gx_rptr <= gx_rptr + PW'(1);
                gy_rptr <= gy_rptr + PW'(1);
            end
            // Simultaneous write and pop on a side cancel out.
            gx_count <= gx_count + AW'(grant_x) - AW'(pop);
            gy_count <= gy_count + AW'(grant_y) - AW'(pop);
            if (elig_x & elig_y) prio <= ~prio;
            if (ld_gx) pair_gx <= bus.mem_data_out;
            if (ld_gy) begin
                pair_gy    <= bus.mem_data_out;
                pair_valid <= 1'b1;
            end else if (pop) begin
                pair_valid <= 1'b0;
            end
        end
    end

    assign bus.gx_ready    = grant_x;
    assign bus.gy_ready    = grant_y;
    assign bus.mem_rd_en   = rd_en & ~rst;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.pair_valid  = pair_valid;
    assign bus.pair_gx     = pair_gx;
    assign bus.pair_gy     = pair_gy;
    assign bus.gx_count    = gx_count;
    assign bus.gy_count    = gy_count;
endmodule

// File: tb/tb_sobel_grad_mem_ctrl.sv
// Bench for sobel_grad_mem_ctrl: queue-based reference of the two gradient streams plus a
// registered-read memory model; each scenario task checks the DUT against that reference.
module tb_sobel_grad_mem_ctrl;
    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 12;
    localparam int          HALF = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_grad_mem_ctrl_if #(.AW(AW), .DW(DW)) bus ();
    sobel_grad_mem_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Gradient memory with one-cycle registered read.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en) bus.mem_data_out <= mem[bus.mem_rd_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference: samples accepted but not yet delivered, per side, in arrival order.
    logic [DW-1:0] q_gx[$];
    logic [DW-1:0] q_gy[$];
    int            w_gx, w_gy, pairs_seen;
    bit            m_prio;
    bit            e_x, e_y, both_el, hs;
    logic [DW-1:0] p_xd, p_yd;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;

    // Apply one cycle of inputs at the falling edge and derive the expected write decision.
    task automatic drive(input bit xv, input logic [DW-1:0] xd, input bit yv,
                         input logic [DW-1:0] yd, input bit pr, input bit r);
        bit el_x, el_y;
        @(negedge clk);
        rst = r;
        bus.gx_valid = xv; bus.gx_data = xd;
        bus.gy_valid = yv; bus.gy_data = yd;
        bus.pair_ready = pr;
        #1;
        el_x    = xv && !r && (q_gx.size() < HALF);
        el_y    = yv && !r && (q_gy.size() < HALF);
        e_x     = el_x && (!el_y || !m_prio);
        e_y     = el_y && (!el_x || m_prio);
        both_el = el_x && el_y;
        hs      = bus.pair_valid && pr && !r;
        p_xd    = xd;
        p_yd    = yd;
        exp_wa  = e_x ? AW'(w_gx % HALF) : (e_y ? AW'(HALF + (w_gy % HALF)) : '0);
        exp_wd  = e_x ? xd : (e_y ? yd : '0);
    endtask

    // Advance through the rising edge and update the reference.
    task automatic commit();
        @(posedge clk);
        if (rst) begin
            q_gx.delete(); q_gy.delete();
            w_gx = 0; w_gy = 0; m_prio = 1'b0; pairs_seen = 0;
        end else begin
            if (hs) begin
                if (q_gx.size() > 0) void'(q_gx.pop_front());
                if (q_gy.size() > 0) void'(q_gy.pop_front());
                pairs_seen++;
            end
            if (e_x) begin q_gx.push_back(p_xd); w_gx++; end
            if (e_y) begin q_gy.push_back(p_yd); w_gy++; end
            if (both_el) m_prio = !m_prio;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 12'h111, 1'b1, 12'h222, 1'b0, 1'b1);
            n_total++; if (bus.gx_ready !== 1'b0 || bus.gy_ready !== 1'b0)
                $display("FAIL reset_ready got %b%b want 00", bus.gx_ready, bus.gy_ready); else n_pass++;
            n_total++; if (bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0)
                $display("FAIL reset_mem_en got wr=%b rd=%b want 0", bus.mem_wr_en, bus.mem_rd_en); else n_pass++;
            n_total++; if (bus.pair_valid !== 1'b0)
                $display("FAIL reset_pair_valid got %b want 0", bus.pair_valid); else n_pass++;
            n_total++; if (bus.gx_count !== '0 || bus.gy_count !== '0)
                $display("FAIL reset_counts got %0d/%0d want 0/0", bus.gx_count, bus.gy_count); else n_pass++;
            commit();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_total++; if (bus.gx_count !== '0 || bus.gy_count !== '0 || bus.pair_valid !== 1'b0)
            $display("FAIL reset_release got cnt %0d/%0d pv=%b want 0/0 0",
                     bus.gx_count, bus.gy_count, bus.pair_valid); else n_pass++;
        commit();
    endtask

    task automatic test_single_pair();
        drive(1'b1, 12'h123, 1'b0, '0, 1'b0, 1'b0);
        n_total++; if (bus.gx_ready !== 1'b1 || bus.mem_wr_en !== 1'b1 || bus.mem_wr_addr !== 10'd0
                       || bus.mem_wr_data !== 12'h123)
            $display("FAIL single_gx_write got rdy=%b en=%b addr=%0d data=%h want 1 1 0 123",
                     bus.gx_ready, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data); else n_pass++;
        commit();
        drive(1'b0, '0, 1'b1, 12'h456, 1'b0, 1'b0);
        n_total++; if (bus.gy_ready !== 1'b1 || bus.mem_wr_addr !== 10'd512 || bus.mem_wr_data !== 12'h456)
            $display("FAIL single_gy_write got rdy=%b addr=%0d data=%h want 1 512 456",
                     bus.gy_ready, bus.mem_wr_addr, bus.mem_wr_data); else n_pass++;
        commit();
        // Gy write was cycle W+1; reads issue in W+2/W+3 and the pair shows in W+5.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, '0, (i == 3), 1'b0);
            n_total++; if (bus.pair_valid !== (i == 3))
                $display("FAIL single_pair_valid step %0d got %b want %b", i, bus.pair_valid, (i == 3)); else n_pass++;
            if (i == 0) begin
                n_total++; if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 10'd0)
                    $display("FAIL single_rd_gx got en=%b addr=%0d want 1 0", bus.mem_rd_en, bus.mem_rd_addr); else n_pass++;
            end
            if (i == 1) begin
                n_total++; if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 10'd512)
                    $display("FAIL single_rd_gy got en=%b addr=%0d want 1 512", bus.mem_rd_en, bus.mem_rd_addr); else n_pass++;
            end
            if (i == 3) begin
                n_total++; if (bus.pair_gx !== 12'h123 || bus.pair_gy !== 12'h456)
                    $display("FAIL single_pair_data got %h/%h want 123/456", bus.pair_gx, bus.pair_gy); else n_pass++;
            end
            commit();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_total++; if (bus.gx_count !== '0 || bus.gy_count !== '0 || bus.pair_valid !== 1'b0)
            $display("FAIL single_after_pop got cnt %0d/%0d pv=%b want 0/0 0",
                     bus.gx_count, bus.gy_count, bus.pair_valid); else n_pass++;
        commit();
    endtask

    task automatic test_contention();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        commit();
        for (int i = 0; i < 48; i++) begin
            drive(1'b1, DW'($urandom), 1'b1, DW'($urandom), 1'b1, 1'b0);
            n_total++; if (bus.gx_ready !== e_x || bus.gy_ready !== e_y)
                $display("FAIL cont_grant cyc %0d got %b%b want %b%b", i, bus.gx_ready, bus.gy_ready, e_x, e_y); else n_pass++;
            n_total++; if (bus.mem_wr_addr !== exp_wa || bus.mem_wr_data !== exp_wd)
                $display("FAIL cont_wr cyc %0d got %0d:%h want %0d:%h", i, bus.mem_wr_addr, bus.mem_wr_data,
                         exp_wa, exp_wd); else n_pass++;
            n_total++; if (bus.gx_count !== AW'(q_gx.size()) || bus.gy_count !== AW'(q_gy.size()))
                $display("FAIL cont_count cyc %0d got %0d/%0d want %0d/%0d", i, bus.gx_count, bus.gy_count,
                         q_gx.size(), q_gy.size()); else n_pass++;
            if (hs) begin
                n_total++; if (q_gx.size() == 0 || q_gy.size() == 0 || bus.pair_gx !== q_gx[0] || bus.pair_gy !== q_gy[0])
                    $display("FAIL cont_pair #%0d got %h/%h want queue front", pairs_seen, bus.pair_gx, bus.pair_gy); else n_pass++;
            end
            commit();
        end
        for (int i = 0; i < 200 && q_gx.size() > 0; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            if (hs) begin
                n_total++; if (q_gx.size() == 0 || q_gy.size() == 0 || bus.pair_gx !== q_gx[0] || bus.pair_gy !== q_gy[0])
                    $display("FAIL cont_drain_pair #%0d got %h/%h want queue front", pairs_seen, bus.pair_gx, bus.pair_gy); else n_pass++;
            end
            commit();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_total++; if (q_gx.size() != 0 || bus.gx_count !== '0 || bus.gy_count !== '0)
            $display("FAIL cont_drained got cnt %0d/%0d left %0d want 0/0 0", bus.gx_count, bus.gy_count, q_gx.size()); else n_pass++;
        commit();
    endtask

    task automatic test_full();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        commit();
        for (int i = 0; i <= HALF; i++) begin
            drive(1'b1, DW'($urandom), 1'b0, '0, 1'b0, 1'b0);
            n_total++; if (bus.gx_ready !== (i < HALF))
                $display("FAIL full_gx_ready sample %0d got %b want %b", i, bus.gx_ready, (i < HALF)); else n_pass++;
            commit();
        end
        drive(1'b1, DW'($urandom), 1'b1, 12'h0AB, 1'b0, 1'b0);
        n_total++; if (bus.gx_count !== 10'd512)
            $display("FAIL full_count got %0d want 512", bus.gx_count); else n_pass++;
        n_total++; if (bus.gx_ready !== 1'b0 || bus.gy_ready !== 1'b1 || bus.mem_wr_addr !== 10'd512)
            $display("FAIL full_gy_pass got %b%b addr %0d want 01 512", bus.gx_ready, bus.gy_ready, bus.mem_wr_addr); else n_pass++;
        commit();
    endtask

    task automatic test_reset_hold();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
            seen = bus.pair_valid;
            if (!seen) commit();
        end
        n_total++; if (!seen)
            $display("FAIL hold_wait got pair_valid=0 want 1 within 8 cycles"); else n_pass++;
        n_total++; if (q_gx.size() == 0 || q_gy.size() == 0 || bus.pair_gx !== q_gx[0] || bus.pair_gy !== q_gy[0])
            $display("FAIL hold_pair got %h/%h want first Gx / 0ab", bus.pair_gx, bus.pair_gy); else n_pass++;
        n_total++; if (bus.gx_count !== 10'd512 || bus.gy_count !== 10'd1)
            $display("FAIL hold_counts got %0d/%0d want 512/1", bus.gx_count, bus.gy_count); else n_pass++;
        commit();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        commit();
        drive(1'b1, 12'h3C5, 1'b0, '0, 1'b0, 1'b0);
        n_total++; if (bus.pair_valid !== 1'b0 || bus.gx_count !== '0 || bus.gy_count !== '0)
            $display("FAIL hold_after_rst got pv=%b cnt %0d/%0d want 0 0/0", bus.pair_valid, bus.gx_count, bus.gy_count); else n_pass++;
        n_total++; if (bus.gx_ready !== 1'b1 || bus.mem_wr_addr !== 10'd0)
            $display("FAIL hold_first_write got rdy=%b addr=%0d want 1 0", bus.gx_ready, bus.mem_wr_addr); else n_pass++;
        commit();
    endtask

    task automatic test_wrap();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        commit();
        for (int i = 0; i < 6000 && pairs_seen < 600; i++) begin
            drive((w_gx < 600) && ($urandom_range(0, 3) != 0), DW'($urandom),
                  (w_gy < 600) && ($urandom_range(0, 3) != 0), DW'($urandom), 1'b1, 1'b0);
            if (e_x && w_gx == 512) begin
                n_total++; if (bus.mem_wr_addr !== 10'd0)
                    $display("FAIL wrap_gx_addr got %0d want 0", bus.mem_wr_addr); else n_pass++;
            end
            if (e_y && w_gy == 512) begin
                n_total++; if (bus.mem_wr_addr !== 10'd512)
                    $display("FAIL wrap_gy_addr got %0d want 512", bus.mem_wr_addr); else n_pass++;
            end
            if (hs) begin
                n_total++; if (q_gx.size() == 0 || q_gy.size() == 0 || bus.pair_gx !== q_gx[0] || bus.pair_gy !== q_gy[0])
                    $display("FAIL wrap_pair #%0d got %h/%h want queue front", pairs_seen, bus.pair_gx, bus.pair_gy); else n_pass++;
            end
            commit();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_total++; if (pairs_seen != 600 || bus.gx_count !== '0 || bus.gy_count !== '0)
            $display("FAIL wrap_done got %0d pairs cnt %0d/%0d want 600 0/0", pairs_seen, bus.gx_count, bus.gy_count); else n_pass++;
        commit();
    endtask

    initial begin
        bus.gx_valid = 1'b0; bus.gx_data = '0;
        bus.gy_valid = 1'b0; bus.gy_data = '0;
        bus.pair_ready = 1'b0;
        w_gx = 0; w_gy = 0; pairs_seen = 0; m_prio = 1'b0;
        test_reset();
        test_single_pair();
        test_contention();
        test_full();
        test_reset_hold();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sobel_grad_mem_ctrl.md
# sobel_grad_mem_ctrl

Controller for the 1024 x 12 Sobel gradient memory. Two producers share the memory's single write port through round-robin arbitration: the horizontal (Gx) gradient stage and the vertical (Gy) gradient stage. The memory is managed as two circular buffers, Gx in the lower half and Gy in the upper half. The read port is sequenced to fetch matching Gx/Gy entries and present them as one pair to the downstream magnitude stage over a valid/ready handshake.

## Interface
Parameters:
- AW, 10, memory address width; each half is 2^(AW-1) = 512 entries deep
- DW, 12, gradient data width

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- gx_valid  in  1  Gx producer has data
- gx_data  in  DW  Gx sample
- gx_ready  out  1  Gx write granted this cycle
- gy_valid  in  1  Gy producer has data
- gy_data  in  DW  Gy sample
- gy_ready  out  1  Gy write granted this cycle
- pair_valid  out  1  pair_gx/pair_gy hold a matched pair
- pair_gx  out  DW  Gx of pair
- pair_gy  out  DW  Gy of pair
- pair_ready  in  1  downstream accepts pair
- mem_wr_en  out  1  memory write enable
- mem_wr_addr  out  AW  memory write address
- mem_wr_data  out  DW  memory write data
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  AW  memory read address
- mem_data_out  in  DW  memory read data, valid exactly 1 cycle after mem_rd_en
- gx_count  out  AW  occupied Gx entries, 0..512
- gy_count  out  AW  occupied Gy entries, 0..512

## Operation
- Address map: Gx entry i is at {1'b0, i[AW-2:0]}; Gy entry i is at {1'b1, i[AW-2:0]}.
- State: gx_wptr, gy_wptr, gx_rptr, gy_rptr (AW-1 bits each, natural wrap 511->0), gx_count, gy_count, prio (0 = Gx), and the read FSM.
- Full is count == 512.
- Write arbitration (combinational):
  - eligible_x = gx_valid & !gx_full; eligible_y = gy_valid & !gy_full.
  - If both are eligible, grant the side named by prio. Otherwise grant whichever side is eligible.
  - gx_ready / gy_ready equal the grants.
  - prio flips to the other side after any cycle in which both sides were eligible. It is otherwise unchanged.
- Write port: on a grant, mem_wr_en=1, mem_wr_addr = granted side's address at its wptr, mem_wr_data = granted data. That wptr increments. With no grant, mem_wr_en=0 and mem_wr_addr/mem_wr_data = 0.
- Counts: +1 on that side's write, -1 on pair handshake (pair_valid & pair_ready). Both events in the same cycle leave the count unchanged.
- Read FSM:
  - IDLE: if gx_count!=0 and gy_count!=0, assert mem_rd_en at Gx address gx_rptr, then go to RD_Y.
  - RD_Y: assert mem_rd_en at Gy address gy_rptr; register mem_data_out into pair_gx; go to CAP.
  - CAP: register mem_data_out into pair_gy; set pair_valid; go to HOLD.
  - HOLD: pair_valid=1 and pair data stable until pair_ready. On handshake, clear pair_valid, increment gx_rptr and gy_rptr, decrement both counts, return to IDLE.
  - Outside IDLE and RD_Y, mem_rd_en=0 and mem_rd_addr=0.
- Read/write collision is impossible. Counts are decremented only at pop, so a write never targets an entry still being read. No bypass logic is needed.
- While rst=1, all combinational outputs (gx_ready, gy_ready, mem_wr_en, mem_rd_en) are forced to 0.

## Timing
- Reset values: pointers 0, counts 0, prio=Gx, FSM=IDLE, pair_valid=0, pair_gx=0, pair_gy=0.
- Reset mid-operation: all buffered entries and any pending pair are discarded. Memory contents are not cleared. The first write after reset goes to address 0 (Gx) or 512 (Gy).
- Write latency: the sample is accepted in the cycle valid & ready; count is updated at that edge.
- Pair latency: last of the two writes fires in cycle W. Counts become nonzero in W+1 (IDLE issues the Gx read). pair_valid is high in W+4.
- Throughput: at most 1 pair per 4 cycles with pair_ready held high.
- Order: pairs are strictly FIFO per side; pair k combines the k-th Gx and k-th Gy samples since reset.
- Full on one side blocks only that side; the other side keeps being granted.

## Test plan
- Reset: assert rst 2 cycles with gx_valid=gy_valid=1 -> gx_ready=gy_ready=0, mem_wr_en=0, pair_valid=0, counts 0 throughout and in the cycle after release.
- Single pair: Gx 0x123 written in cycle W, Gy 0x456 written in W+1 -> writes to addresses 0 and 512; pair_valid in W+5 with pair_gx=0x123, pair_gy=0x456; counts return to 0 after handshake.
- Contention: gx_valid=gy_valid=1 continuously from reset, pair_ready=1 -> grants X,Y,X,Y...; write addresses 0,512,1,513,...; pairs emerge in order.
- Full: pair_ready=0, 513 Gx samples offered, gy idle -> gx_count reaches 512 and gx_ready drops; a Gy sample is still accepted the next cycle.
- Wrap: stream 600 Gx/Gy pairs with pair_ready=1 -> Gx sample 512 is written at address 0 and Gy sample 512 at address 512; all 600 pairs are delivered in order with correct data.
- Reset in HOLD: assert rst while pair_valid=1 and counts are nonzero -> next cycle pair_valid=0 and counts 0; the following Gx write lands at address 0.
